systolic_drain_ctrl: RTL and testbench
======================================

# systolic_drain_ctrl

Output-side controller for the systolic MAC array. Once the load/MAC controller has drained its input FIFOs, this block waits for the array wavefront to settle, then reads the accumulator matrix one row at a time. It serializes the results row-major onto a val/rdy output stream, clears the accumulators, and reports completion. It is the unload counterpart to the load-side controller and sits between the PE array and the downstream result consumer.

## Interface
Parameters:
- `SIZE`, 4: array dimension; the array holds SIZE×SIZE accumulators.
- `DATA_W`, 32: accumulator/result width in bits.
- `FLUSH`, 2*SIZE-1: settle cycles after `start` before accumulators are final; must be ≥1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse from the MAC controller: input FIFOs empty, drain may begin.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the drain and accumulator clear are complete.
- `row_ren`  out  1  row read strobe to the array.
- `row_addr`  out  $clog2(SIZE)  row index; valid while `row_ren`=1.
- `row_data`  in  SIZE*DATA_W  row read data, valid one cycle after `row_ren`; element c is `[c*DATA_W +: DATA_W]`.
- `acc_clr`  out  1  one-cycle clear of all PE accumulators.
- `out_msg`  out  DATA_W  result element.
- `out_val`  out  1  `out_msg` is valid.
- `out_rdy`  in  1  consumer accepts the element.
- `out_last`  out  1  high with the final element (row SIZE-1, col SIZE-1).

## Operation
The block is a state machine with states IDLE, FLUSH, READ, CAPTURE, SEND, CLEAR.
- **IDLE:** all outputs 0. If `start`=1: load the settle counter with FLUSH, set row=0, and go to FLUSH.
- **FLUSH:** decrement the counter each cycle. When the counter is 1, go to READ. FLUSH lasts exactly FLUSH cycles.
- **READ:** drive `row_ren`=1 and `row_addr`=row for one cycle, then go to CAPTURE.
- **CAPTURE:** register `row_data` into a SIZE×DATA_W row buffer, set col=0, and go to SEND.
- **SEND:**
  - Drive `out_val`=1 and `out_msg`=buf[col]; `out_last`=(row==SIZE-1 && col==SIZE-1).
  - On `out_val & out_rdy`:
    - if col<SIZE-1, increment col;
    - else if row<SIZE-1, increment row and go to READ;
    - else go to CLEAR.
- **CLEAR:** `acc_clr`=1 and `done`=1 for one cycle, then go to IDLE.

Rules that apply in all states:
- `start` is ignored outside IDLE. It is neither queued nor an error.
- Output order is row-major: (0,0),(0,1),…,(SIZE-1,SIZE-1), for SIZE² transfers in total.
- Data is passed through unmodified; there is no arithmetic on results. Row and col counters never wrap within a drain.

## Timing
- **Reset:** asserting `rst` low forces IDLE immediately (asynchronous). All counters and the row buffer go to 0, and every output is 0. This holds mid-drain too. A partially sent matrix is abandoned and `acc_clr` is not issued; the MAC controller resets alongside this block.
- **Read latency:** exactly one cycle from `row_ren` to `row_data` capture.
- **Handshake:**
  - A transfer occurs on any cycle with `out_val & out_rdy`.
  - While `out_val`=1 and `out_rdy`=0, `out_msg`, `out_last` and `out_val` hold stable.
  - `out_val` never depends combinationally on `out_rdy`.
- **Gaps:** `out_val` drops for 2 cycles (READ, CAPTURE) between rows.
- **Latency with `out_rdy` tied high:** `done` asserts FLUSH + SIZE*(SIZE+2) + 1 cycles after the edge that samples `start`. For defaults this is 32.
- **Back-to-back:** a `start` on the cycle after `done` (IDLE) is accepted.

## Structure
- `systolic_pkg` holds the state enum `drain_state_t`. It also holds the shared default constants `SYS_SIZE` and `SYS_DATA_W`, which this block and the load-side controller both use.
- The block is a single module with no sub-module; the row buffer and counters are local.

## Test plan
- **Basic drain:** SIZE=4, accumulator (r,c)=16r+c, `out_rdy`=1, pulse `start`. Expect 16 transfers with values 0,1,2,3,16,…,51, `out_last` only on 51, `acc_clr`/`done` at cycle 32.
- **Backpressure:** toggle `out_rdy` pseudo-randomly. Expect the same 16 values in order, `out_msg` stable while stalled, and exactly one `acc_clr`.
- **Start while busy:** pulse `start` during FLUSH and again during SEND. Expect one drain of 16 elements and one `done`.
- **Reset mid-drain:** assert `rst` after the 5th transfer. Expect all outputs 0 immediately and no `acc_clr`. A fresh `start` then yields the full 16 elements from (0,0).
- **SIZE=2, FLUSH=3:** with values 7,8,9,10. Expect that order and `done` at cycle 3+8+1=12.
- **Back-to-back:** two drains with `start` the cycle after `done`. Expect 32 transfers with no loss.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : Shared array constants and drain-controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int SYS_SIZE   = 4;
    localparam int SYS_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4,
        ST_CLEAR   = 3'd5
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_drain_ctrl
// Brief    : Waits for the array wavefront to settle, reads accumulator rows,
//            streams them row-major on val/rdy, then clears the accumulators.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_drain_ctrl
    import systolic_pkg::*;
#(
    parameter int SIZE   = SYS_SIZE,
    parameter int DATA_W = SYS_DATA_W,
    parameter int FLUSH  = 2*SIZE-1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      row_ren,
    output logic [$clog2(SIZE)-1:0]   row_addr,
    input  logic [SIZE*DATA_W-1:0]    row_data,
    output logic                      acc_clr,
    output logic [DATA_W-1:0]         out_msg,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic                      out_last
);

    localparam int c_row_w = $clog2(SIZE);
    localparam int c_cnt_w = $clog2(FLUSH+1);

    drain_state_t                    r_state;
    drain_state_t                    w_next_state;
    logic [c_cnt_w-1:0]              r_cnt;
    logic [c_row_w-1:0]              r_row;
    logic [c_row_w-1:0]              r_col;
    logic [SIZE-1:0][DATA_W-1:0]     r_buf;
    logic                            w_col_last;
    logic                            w_row_last;

    assign w_col_last = (r_col == c_row_w'(SIZE-1));
    assign w_row_last = (r_row == c_row_w'(SIZE-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next_state = ST_FLUSH;
            ST_FLUSH:   if (r_cnt == c_cnt_w'(1)) w_next_state = ST_READ;
            ST_READ:    w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_SEND;
            ST_SEND: begin
                if (out_rdy && w_col_last) begin
                    w_next_state = w_row_last ? ST_CLEAR : ST_READ;
                end
            end
            ST_CLEAR:   w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Counters and row buffer; the element index only advances on an accepted transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_row <= '0;
            r_col <= '0;
            r_buf <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt <= c_cnt_w'(FLUSH);
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                ST_FLUSH: r_cnt <= r_cnt - c_cnt_w'(1);
                ST_CAPTURE: begin
                    r_buf <= row_data;
                    r_col <= '0;
                end
                ST_SEND: begin
                    if (out_rdy) begin
                        if (!w_col_last) begin
                            r_col <= r_col + c_row_w'(1);
                        end else if (!w_row_last) begin
                            r_row <= r_row + c_row_w'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (r_state != ST_IDLE);
        row_ren  = 1'b0;
        row_addr = '0;
        out_val  = 1'b0;
        out_msg  = '0;
        out_last = 1'b0;
        acc_clr  = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_READ: begin
                row_ren  = 1'b1;
                row_addr = r_row;
            end
            ST_SEND: begin
                out_val  = 1'b1;
                out_msg  = r_buf[r_col];
                out_last = w_row_last && w_col_last;
            end
            ST_CLEAR: begin
                acc_clr = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_drain_ctrl
// Brief    : Self-checking bench for the drain controller (4x4 and 2x2 arrays).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_drain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4x4, default settle time
    logic        rst4 = 1'b0, start4 = 1'b0, rdy4 = 1'b0;
    logic        busy4, done4, ren4, clr4, val4, last4;
    logic [1:0]  addr4;
    logic [127:0] rdata4;
    logic [31:0] msg4;

    // 2x2, settle time 3
    logic        rst2 = 1'b0, start2 = 1'b0, rdy2 = 1'b0;
    logic        busy2, done2, ren2, clr2, val2, last2;
    logic [0:0]  addr2;
    logic [63:0] rdata2;
    logic [31:0] msg2;

    systolic_drain_ctrl u_d4 (
        .clk(clk), .rst(rst4), .start(start4), .busy(busy4), .done(done4),
        .row_ren(ren4), .row_addr(addr4), .row_data(rdata4), .acc_clr(clr4),
        .out_msg(msg4), .out_val(val4), .out_rdy(rdy4), .out_last(last4)
    );

    systolic_drain_ctrl #(.SIZE(2), .DATA_W(32), .FLUSH(3)) u_d2 (
        .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
        .row_ren(ren2), .row_addr(addr2), .row_data(rdata2), .acc_clr(clr2),
        .out_msg(msg2), .out_val(val2), .out_rdy(rdy2), .out_last(last2)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accumulator array models: read data is only meaningful the cycle after row_ren.
    logic [31:0] mem4 [4][4];
    logic [31:0] mem2 [2][2];

    always @(posedge clk) begin
        for (int c = 0; c < 4; c++)
            rdata4[c*32 +: 32] <= ren4 ? mem4[addr4][c] : $urandom;
        for (int c = 0; c < 2; c++)
            rdata2[c*32 +: 32] <= ren2 ? mem2[addr2][c] : $urandom;
    end

    // 4x4 stream monitor
    logic [31:0] got_msg[$];
    logic        got_last[$];
    int          cyc4 = 0, done_cnt4 = 0, clr_cnt4 = 0, done_at4 = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_msg;
    logic        prev_last;

    always @(negedge clk) begin
        cyc4++;
        if (!rst4) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_val", val4, 1'b1);
                chk("hold_msg", msg4, prev_msg);
                chk("hold_last", last4, prev_last);
            end
            stall_prev = val4 && !rdy4;
            prev_msg   = msg4;
            prev_last  = last4;
            if (val4 && rdy4) begin
                got_msg.push_back(msg4);
                got_last.push_back(last4);
            end
            if (done4) begin
                done_cnt4++;
                done_at4 = cyc4;
            end
            if (clr4) clr_cnt4++;
        end
    end

    task automatic fill4(input bit rnd);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mem4[r][c] = rnd ? $urandom : 32'(16*r + c);
    endtask

    task automatic drain4(input bit rnd_rdy, input bit poke, input bit imm,
                          input int exp_n, input int exp_lat);
        bit timeout;
        got_msg.delete();
        got_last.delete();
        done_cnt4 = 0;
        clr_cnt4  = 0;
        done_at4  = 0;
        if (!imm) begin
            @(posedge clk); #1;
        end
        start4 = 1'b1;
        rdy4   = rnd_rdy ? 1'($urandom % 2) : 1'b1;
        @(posedge clk); #1;
        cyc4   = 0;
        start4 = 1'b0;
        timeout = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (done_cnt4 != 0) begin
                timeout = 1'b0;
                break;
            end
            rdy4   = rnd_rdy ? 1'($urandom % 2) : 1'b1;
            start4 = poke && (cyc4 == 2 || cyc4 == 10);
            @(posedge clk); #1;
        end
        start4 = 1'b0;
        chk("drain_timeout", timeout, 1'b0);
        chk("n_xfer", got_msg.size(), exp_n);
        for (int i = 0; i < got_msg.size() && i < 16; i++) begin
            chk("xfer_msg", got_msg[i], mem4[i/4][i%4]);
            chk("xfer_last", got_last[i], i == 15);
        end
        chk("done_cnt", done_cnt4, 1);
        chk("acc_clr_cnt", clr_cnt4, 1);
        if (exp_lat > 0) chk("done_latency", done_at4, exp_lat);
    endtask

    task automatic chk_idle4(input string nm);
        chk({nm, "_busy"}, busy4, 1'b0);
        chk({nm, "_done"}, done4, 1'b0);
        chk({nm, "_ren"}, ren4, 1'b0);
        chk({nm, "_addr"}, addr4, 2'd0);
        chk({nm, "_clr"}, clr4, 1'b0);
        chk({nm, "_val"}, val4, 1'b0);
        chk({nm, "_msg"}, msg4, 32'd0);
        chk({nm, "_last"}, last4, 1'b0);
    endtask

    typedef struct {
        bit rnd_data;
        bit rnd_rdy;
        bit poke;
        int exp_n;
        int exp_lat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [31:0] q2[$];
        logic        l2[$];
        int          c2, d2_at;
        bit          seen;

        vecs[0] = '{rnd_data: 1'b0, rnd_rdy: 1'b0, poke: 1'b0, exp_n: 16, exp_lat: 32};
        vecs[1] = '{rnd_data: 1'b1, rnd_rdy: 1'b1, poke: 1'b0, exp_n: 16, exp_lat: 0};
        vecs[2] = '{rnd_data: 1'b1, rnd_rdy: 1'b0, poke: 1'b1, exp_n: 16, exp_lat: 32};
        vecs[3] = '{rnd_data: 1'b0, rnd_rdy: 1'b1, poke: 1'b0, exp_n: 16, exp_lat: 0};

        repeat (3) @(posedge clk);
        #1;
        chk_idle4("reset");
        chk("reset2_busy", busy2, 1'b0);
        chk("reset2_val", val2, 1'b0);
        rst4 = 1'b1;
        rst2 = 1'b1;
        @(posedge clk); #1;
        chk_idle4("idle");

        for (int v = 0; v < 4; v++) begin
            fill4(vecs[v].rnd_data);
            drain4(vecs[v].rnd_rdy, vecs[v].poke, 1'b0, vecs[v].exp_n, vecs[v].exp_lat);
        end

        // Reset after the 5th transfer, then a fresh full drain
        fill4(1'b1);
        got_msg.delete();
        got_last.delete();
        clr_cnt4 = 0;
        rdy4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (got_msg.size() >= 5) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_reach5", seen, 1'b1);
        rst4 = 1'b0;
        #1;
        chk_idle4("midrst");
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_clr", clr_cnt4, 0);
        chk_idle4("midrst_hold");
        rst4 = 1'b1;
        drain4(1'b0, 1'b0, 1'b0, 16, 32);

        // Back-to-back: second start in the cycle right after done
        fill4(1'b1);
        drain4(1'b0, 1'b0, 1'b0, 16, 32);
        fill4(1'b1);
        drain4(1'b0, 1'b0, 1'b1, 16, 32);
        fill4(1'b0);
        drain4(1'b1, 1'b0, 1'b1, 16, 0);

        // 2x2 array with settle time 3
        mem2[0][0] = 32'd7;
        mem2[0][1] = 32'd8;
        mem2[1][0] = 32'd9;
        mem2[1][1] = 32'd10;
        rdy2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        c2 = 0;
        d2_at = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            c2++;
            if (val2 && rdy2) begin
                q2.push_back(msg2);
                l2.push_back(last2);
            end
            if (done2) begin
                d2_at = c2;
                chk("s2_clr", clr2, 1'b1);
                break;
            end
        end
        chk("s2_done_at", d2_at, 12);
        chk("s2_n_xfer", q2.size(), 4);
        for (int i = 0; i < q2.size() && i < 4; i++) begin
            chk("s2_msg", q2[i], 32'(7 + i));
            chk("s2_last", l2[i], i == 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
